// File: rtl/tomasula_types.sv
// Shared Tomasulo back-end types: control word, CDB broadcast, ALU issue word
// and the reservation-station entry record.
package tomasula_types;

  localparam int RS_DEPTH_DEFAULT = 4;
  localparam int ROB_TAG_W        = 3;
  localparam int DATA_W           = 32;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef logic [DATA_W-1:0]    data_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    rob_tag_t   rd_tag;
    data_t      imm;
  } ctl_word;

  typedef struct packed {
    logic     valid;
    rob_tag_t tag;
    data_t    data;
  } cdb_data;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    data_t      src1_data;
    data_t      src2_data;
    data_t      imm;
    rob_tag_t   tag;
  } alu_word;

  typedef struct packed {
    logic     ready;
    rob_tag_t tag;
    data_t    data;
  } rs_src_t;

  typedef struct packed {
    logic    valid;
    ctl_word ctl;
    rs_src_t src1;
    rs_src_t src2;
  } rs_entry_t;

  function automatic logic cdb_hit(input cdb_data bus, input rob_tag_t tag);
    return bus.valid && (bus.tag == tag);
  endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: storage plus alloc-cycle CDB bypass and
// per-source wakeup compare.
module rs_entry
  import tomasula_types::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     flush_i,
  input  logic     alloc_i,
  input  logic     clear_i,
  input  ctl_word  ctl_i,
  input  data_t    src1_i,
  input  data_t    src2_i,
  input  rob_tag_t tag1_i,
  input  rob_tag_t tag2_i,
  input  logic     pend1_i,
  input  logic     pend2_i,
  input  cdb_data  cdb_i,
  output logic     valid_o,
  output logic     ready_o,
  output ctl_word  ctl_o,
  output data_t    src1_data_o,
  output data_t    src2_data_o
);

  rs_entry_t entry_q, entry_d;

  function automatic rs_src_t load_src(input data_t val, input rob_tag_t tag,
                                       input logic pend, input cdb_data bus);
    rs_src_t s;
    s.tag   = tag;
    s.ready = !pend;
    s.data  = val;
    if (pend && cdb_hit(bus, tag)) begin
      s.ready = 1'b1;
      s.data  = bus.data;
    end
    return s;
  endfunction

  // A source that is already ready keeps its value even if its old tag is rebroadcast.
  function automatic rs_src_t wake_src(input rs_src_t s, input cdb_data bus);
    rs_src_t r;
    r = s;
    if (!s.ready && cdb_hit(bus, s.tag)) begin
      r.ready = 1'b1;
      r.data  = bus.data;
    end
    return r;
  endfunction

  always_comb begin
    entry_d = entry_q;
    if (entry_q.valid) begin
      entry_d.src1 = wake_src(entry_q.src1, cdb_i);
      entry_d.src2 = wake_src(entry_q.src2, cdb_i);
    end
    if (clear_i) entry_d.valid = 1'b0;
    if (alloc_i) begin
      entry_d.valid = 1'b1;
      entry_d.ctl   = ctl_i;
      entry_d.src1  = load_src(src1_i, tag1_i, pend1_i, cdb_i);
      entry_d.src2  = load_src(src2_i, tag2_i, pend2_i, cdb_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) entry_q <= '0;
    else                  entry_q <= entry_d;
  end

  assign valid_o     = entry_q.valid;
  assign ready_o     = entry_q.valid && entry_q.src1.ready && entry_q.src2.ready;
  assign ctl_o       = entry_q.ctl;
  assign src1_data_o = entry_q.src1.data;
  assign src2_data_o = entry_q.src2.data;

endmodule

// File: rtl/rs_bank.sv
// Multi-entry reservation station: lowest-free allocation, CDB snooping,
// and oldest-ready issue selected through an age matrix.
module rs_bank
  import tomasula_types::*;
#(
  parameter int  DEPTH = RS_DEPTH_DEFAULT,
  parameter int  TAG_W = ROB_TAG_W,
  parameter int  XLEN  = DATA_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             alloc_valid_i,
  output logic             alloc_ready_o,
  input  ctl_word          control_word_i,
  input  logic [XLEN-1:0]  src1_i,
  input  logic [XLEN-1:0]  src2_i,
  input  logic [TAG_W-1:0] rob_tag1_i,
  input  logic [TAG_W-1:0] rob_tag2_i,
  input  logic             rob_v1_i,
  input  logic             rob_v2_i,
  input  cdb_data          cdb_i,
  input  logic             issue_ready_i,
  output logic             issue_valid_o,
  output alu_word          alu_data_o,
  output logic [CNT_W-1:0] count_o
);

  if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
    $error("rs_bank: DEPTH must be in 2..16");
  end
  if (TAG_W != ROB_TAG_W || XLEN != DATA_W) begin : g_bad_width
    $error("rs_bank: TAG_W/XLEN must match tomasula_types widths");
  end

  logic [DEPTH-1:0] valid_w, ready_w, free_oh, sel_oh, alloc_w, clear_w;
  ctl_word          ctl_w  [DEPTH];
  data_t            s1_w   [DEPTH];
  data_t            s2_w   [DEPTH];
  logic             alloc_fire;

  // age_q[i][j] set means entry i was allocated before entry j.
  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;

  assign alloc_ready_o = ~&valid_w;
  assign alloc_fire    = alloc_valid_i & alloc_ready_o & ~flush_i;
  assign free_oh       = ~valid_w & (valid_w + DEPTH'(1));
  assign alloc_w       = alloc_fire ? free_oh : '0;
  assign clear_w       = sel_oh & {DEPTH{issue_ready_i}};

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    rs_entry u_entry (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .alloc_i     (alloc_w[g]),
      .clear_i     (clear_w[g]),
      .ctl_i       (control_word_i),
      .src1_i      (src1_i),
      .src2_i      (src2_i),
      .tag1_i      (rob_tag1_i),
      .tag2_i      (rob_tag2_i),
      .pend1_i     (rob_v1_i),
      .pend2_i     (rob_v2_i),
      .cdb_i       (cdb_i),
      .valid_o     (valid_w[g]),
      .ready_o     (ready_w[g]),
      .ctl_o       (ctl_w[g]),
      .src1_data_o (s1_w[g]),
      .src2_data_o (s2_w[g])
    );
  end

  // A new entry is younger than every slot; stale bits toward free slots never matter.
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (alloc_w[i])      age_d[i][j] = 1'b0;
        else if (alloc_w[j]) age_d[i][j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) age_q <= '0;
    else                  age_q <= age_d;
  end

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh[i] = ready_w[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready_w[j] && age_q[j][i]) sel_oh[i] = 1'b0;
      end
    end
  end

  assign issue_valid_o = |ready_w;

  always_comb begin
    alu_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) begin
        alu_data_o.op        = ctl_w[i].op;
        alu_data_o.funct3    = ctl_w[i].funct3;
        alu_data_o.funct7    = ctl_w[i].funct7;
        alu_data_o.src1_data = s1_w[i];
        alu_data_o.src2_data = s2_w[i];
        alu_data_o.imm       = ctl_w[i].imm;
        alu_data_o.tag       = ctl_w[i].rd_tag;
      end
    end
  end

  always_comb begin
    count_o = '0;
    for (int i = 0; i < DEPTH; i++) count_o = count_o + CNT_W'(valid_w[i]);
  end

endmodule
